// File: rtl/if_fetch.sv
// Instruction fetch: one outstanding imem request feeding a 2-entry {pc, instr} buffer.
// Latency: request accepted in cycle N, response in N+1 at the earliest, instr_valid in N+2.
// Backpressure: stall holds the head, and requests stop while the buffer holds 2 entries.
// Optional perf counter (fetch_bubbles) is built when IF_PERF_COUNT_EN is defined.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in_data,
  input  logic        redirect,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc_out_data,
  output logic [31:0] plusFour_out_data
`ifdef IF_PERF_COUNT_EN
  ,
  output logic [31:0] fetch_bubbles
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Fetch PC is held as a word address; the byte offset is always zero.
  logic [29:0] r_fpc;
  logic [29:0] r_req_pc;

  logic [31:0] r_fifo_pc  [2];
  logic [31:0] r_fifo_dat [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_cnt;

  logic        w_req;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_unused;

  // Redirect targets are forced word-aligned, so their low bits are never used.
  assign w_unused = &{1'b0, pc_in_data[1:0]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: a redirect must still swallow a request already in flight.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FETCH: begin
        if (redirect) begin
          w_state_nxt = w_accept ? DRAIN : FETCH;
        end else if (w_accept) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          w_state_nxt = FETCH;
        end else if (redirect) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // The stale response retires the outstanding request even if a
        // redirect lands in the same cycle; nothing else is pending then.
        if (imem_rvalid) begin
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  // FSM outputs and buffer control strobes; redirect overrides push and pop.
  always_comb begin
    w_req    = !rst && (r_state == FETCH) && (r_cnt < 2'd2);
    w_accept = w_req && imem_ready;
    w_push   = (r_state == WAIT) && imem_rvalid && !redirect;
    w_pop    = instr_valid && !stall && !redirect;
  end

  assign imem_req  = w_req;
  assign imem_addr = {r_fpc, 2'b00};

  // Fetch PC, request PC tracking and buffer pointers/count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fpc    <= RESET_PC[31:2];
      r_req_pc <= 30'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_accept) begin
        r_req_pc <= r_fpc;
      end

      if (redirect) begin
        r_fpc <= pc_in_data[31:2];
      end else if (w_accept) begin
        r_fpc <= r_fpc + 30'd1;
      end

      if (redirect) begin
        r_rd_ptr <= 1'b0;
        r_wr_ptr <= 1'b0;
        r_cnt    <= 2'd0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + 2'd1;
          2'b01:   r_cnt <= r_cnt - 2'd1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  // Buffer storage; entries are only visible through the count, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]  <= {r_req_pc, 2'b00};
      r_fifo_dat[r_wr_ptr] <= imem_rdata;
    end
  end

  assign instr_valid       = (r_cnt != 2'd0);
  assign instr             = instr_valid ? r_fifo_dat[r_rd_ptr] : 32'd0;
  assign pc_out_data       = instr_valid ? r_fifo_pc[r_rd_ptr] : 32'd0;
  assign plusFour_out_data = pc_out_data + 32'd4;

`ifdef IF_PERF_COUNT_EN
  logic [31:0] r_bubbles;

  // Count every out-of-reset cycle in which decode has nothing to consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubbles <= 32'd0;
    end else if (!instr_valid) begin
      r_bubbles <= r_bubbles + 32'd1;
    end
  end

  assign fetch_bubbles = r_bubbles;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: cycle-by-cycle directed vector table plus short hand sequences
// for the wrap-around reset PC and the optional bubble counter.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in_data;
  logic        redirect;
  logic        stall;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        a_req, b_req;
  logic [31:0] a_addr, b_addr;
  logic [31:0] a_instr, b_instr;
  logic        a_vld, b_vld;
  logic [31:0] a_pc, b_pc;
  logic [31:0] a_p4, b_p4;
`ifdef IF_PERF_COUNT_EN
  logic [31:0] a_bubbles, b_bubbles;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  if_fetch #(.RESET_PC(32'h0000_0000)) u_dut_a (
    .clk(clk), .rst(rst), .pc_in_data(pc_in_data), .redirect(redirect), .stall(stall),
    .imem_req(a_req), .imem_addr(a_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(a_instr), .instr_valid(a_vld), .pc_out_data(a_pc), .plusFour_out_data(a_p4)
`ifdef IF_PERF_COUNT_EN
    , .fetch_bubbles(a_bubbles)
`endif
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_b (
    .clk(clk), .rst(rst), .pc_in_data(pc_in_data), .redirect(redirect), .stall(stall),
    .imem_req(b_req), .imem_addr(b_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(b_instr), .instr_valid(b_vld), .pc_out_data(b_pc), .plusFour_out_data(b_p4)
`ifdef IF_PERF_COUNT_EN
    , .fetch_bubbles(b_bubbles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        redirect;
    logic [31:0] pc_in;
    logic        stall;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_vld;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic r, input logic rd, input logic [31:0] pci,
                             input logic st, input logic rdy, input logic rv,
                             input logic [31:0] rdat, input logic ereq,
                             input logic [31:0] eaddr, input logic evld,
                             input logic [31:0] epc, input logic [31:0] einstr);
    vec_t t;
    t.rst = r; t.redirect = rd; t.pc_in = pci; t.stall = st; t.ready = rdy;
    t.rvalid = rv; t.rdata = rdat; t.exp_req = ereq; t.exp_addr = eaddr;
    t.exp_vld = evld; t.exp_pc = epc; t.exp_instr = einstr;
    return t;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got 0x%08h, expected 0x%08h", name, row, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; outputs are then sampled 1ns later.
  task automatic drive(input logic r, input logic rd, input logic [31:0] pci,
                       input logic st, input logic rdy, input logic rv,
                       input logic [31:0] rdat);
    @(negedge clk);
    rst = r; redirect = rd; pc_in_data = pci; stall = st;
    imem_ready = rdy; imem_rvalid = rv; imem_rdata = rdat;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; redirect = 1'b0; pc_in_data = 32'd0; stall = 1'b0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'd0;

    //                 rst rd pc_in       st rdy rv rdata            req addr        vld pc         instr
    // Reset, then zero-wait streaming from 0.
    vecs.push_back(v(1, 0, 32'h0,     0, 1, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h0));
    vecs.push_back(v(1, 0, 32'h0,     0, 1, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h0));
    vecs.push_back(v(0, 0, 32'h0,     0, 1, 0, 32'h0,        1, 32'h0,   0, 32'h0,   32'h0));
    vecs.push_back(v(0, 0, 32'h0,     0, 1, 1, 32'h13,       0, 32'h4,   0, 32'h0,   32'h0));
    vecs.push_back(v(0, 0, 32'h0,     0, 1, 0, 32'h0,        1, 32'h4,   1, 32'h0,   32'h13));
    vecs.push_back(v(0, 0, 32'h0,     0, 1, 1, 32'h00100093, 0, 32'h8,   0, 32'h0,   32'h0));
    // Not ready: address must hold.
    vecs.push_back(v(0, 0, 32'h0,     0, 0, 0, 32'h0,        1, 32'h8,   1, 32'h4,   32'h00100093));
    vecs.push_back(v(0, 0, 32'h0,     0, 1, 0, 32'h0,        1, 32'h8,   0, 32'h0,   32'h0));
    vecs.push_back(v(0, 0, 32'h0,     0, 1, 1, 32'h00200113, 0, 32'hC,   0, 32'h0,   32'h0));
    // Stall fills the buffer to 2 and blocks further requests.
    vecs.push_back(v(0, 0, 32'h0,     1, 1, 0, 32'h0,        1, 32'hC,   1, 32'h8,   32'h00200113));
    vecs.push_back(v(0, 0, 32'h0,     1, 1, 1, 32'h00300193, 0, 32'h10,  1, 32'h8,   32'h00200113));
    vecs.push_back(v(0, 0, 32'h0,     1, 1, 0, 32'h0,        0, 32'h10,  1, 32'h8,   32'h00200113));
    vecs.push_back(v(0, 0, 32'h0,     1, 1, 0, 32'h0,        0, 32'h10,  1, 32'h8,   32'h00200113));
    vecs.push_back(v(0, 0, 32'h0,     0, 1, 0, 32'h0,        0, 32'h10,  1, 32'h8,   32'h00200113));
    vecs.push_back(v(0, 0, 32'h0,     1, 1, 0, 32'h0,        1, 32'h10,  1, 32'hC,   32'h00300193));
    // Redirect to 0x103 while waiting: flush, drain late response, refetch at 0x100.
    vecs.push_back(v(0, 1, 32'h103,   1, 1, 0, 32'h0,        0, 32'h14,  1, 32'hC,   32'h00300193));
    vecs.push_back(v(0, 0, 32'h0,     0, 1, 1, 32'hDEADBEEF, 0, 32'h100, 0, 32'h0,   32'h0));
    vecs.push_back(v(0, 0, 32'h0,     0, 1, 0, 32'h0,        1, 32'h100, 0, 32'h0,   32'h0));
    vecs.push_back(v(0, 0, 32'h0,     0, 1, 1, 32'h00400213, 0, 32'h104, 0, 32'h0,   32'h0));
    vecs.push_back(v(0, 0, 32'h0,     1, 1, 0, 32'h0,        1, 32'h104, 1, 32'h100, 32'h00400213));
    // Redirect together with rvalid and pop: response dropped, straight to FETCH.
    vecs.push_back(v(0, 1, 32'h200,   0, 1, 1, 32'h00500293, 0, 32'h108, 1, 32'h100, 32'h00400213));
    vecs.push_back(v(0, 0, 32'h0,     0, 0, 0, 32'h0,        1, 32'h200, 0, 32'h0,   32'h0));
    // Redirect with same-cycle acceptance goes to DRAIN; redirect in DRAIN stays there.
    vecs.push_back(v(0, 1, 32'h300,   0, 1, 0, 32'h0,        1, 32'h200, 0, 32'h0,   32'h0));
    vecs.push_back(v(0, 1, 32'h404,   0, 1, 0, 32'h0,        0, 32'h300, 0, 32'h0,   32'h0));
    vecs.push_back(v(0, 0, 32'h0,     0, 1, 1, 32'hCAFEF00D, 0, 32'h404, 0, 32'h0,   32'h0));
    // Spurious rvalid in FETCH is ignored.
    vecs.push_back(v(0, 0, 32'h0,     0, 0, 1, 32'h0BAD0BAD, 1, 32'h404, 0, 32'h0,   32'h0));
    vecs.push_back(v(0, 0, 32'h0,     0, 0, 0, 32'h0,        1, 32'h404, 0, 32'h0,   32'h0));
    // Reset again with stall held: exactly pc 0x0 and 0x4 buffered.
    vecs.push_back(v(1, 0, 32'h0,     1, 1, 0, 32'h0,        0, 32'h404, 0, 32'h0,   32'h0));
    vecs.push_back(v(1, 0, 32'h0,     1, 1, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h0));
    vecs.push_back(v(0, 0, 32'h0,     1, 1, 0, 32'h0,        1, 32'h0,   0, 32'h0,   32'h0));
    vecs.push_back(v(0, 0, 32'h0,     1, 1, 1, 32'h11,       0, 32'h4,   0, 32'h0,   32'h0));
    vecs.push_back(v(0, 0, 32'h0,     1, 1, 0, 32'h0,        1, 32'h4,   1, 32'h0,   32'h11));
    vecs.push_back(v(0, 0, 32'h0,     1, 1, 1, 32'h22,       0, 32'h8,   1, 32'h0,   32'h11));
    vecs.push_back(v(0, 0, 32'h0,     1, 1, 0, 32'h0,        0, 32'h8,   1, 32'h0,   32'h11));
    vecs.push_back(v(0, 0, 32'h0,     1, 1, 1, 32'h33,       0, 32'h8,   1, 32'h0,   32'h11));
    vecs.push_back(v(0, 0, 32'h0,     0, 1, 0, 32'h0,        0, 32'h8,   1, 32'h0,   32'h11));
    vecs.push_back(v(0, 0, 32'h0,     1, 0, 0, 32'h0,        1, 32'h8,   1, 32'h4,   32'h22));
    vecs.push_back(v(0, 0, 32'h0,     1, 0, 0, 32'h0,        1, 32'h8,   1, 32'h4,   32'h22));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].redirect, vecs[i].pc_in, vecs[i].stall,
            vecs[i].ready, vecs[i].rvalid, vecs[i].rdata);
      chk("imem_req",          i, {31'd0, a_req}, {31'd0, vecs[i].exp_req});
      chk("imem_addr",         i, a_addr,         vecs[i].exp_addr);
      chk("instr_valid",       i, {31'd0, a_vld}, {31'd0, vecs[i].exp_vld});
      chk("pc_out_data",       i, a_pc,           vecs[i].exp_pc);
      chk("instr",             i, a_instr,        vecs[i].exp_instr);
      chk("plusFour_out_data", i, a_p4,           vecs[i].exp_pc + 32'd4);
    end

    // RESET_PC = 0xFFFF_FFFC: fetch address and pc+4 wrap to zero.
    drive(1, 0, 32'h0, 0, 1, 0, 32'h0);
    drive(1, 0, 32'h0, 0, 1, 0, 32'h0);
    chk("wrap_reset_req",   100, {31'd0, b_req}, 32'd0);
    chk("wrap_reset_addr",  100, b_addr, 32'hFFFF_FFFC);
    chk("wrap_reset_p4",    100, b_p4,   32'd4);
    drive(0, 0, 32'h0, 0, 1, 0, 32'h0);
    chk("wrap_first_req",   101, {31'd0, b_req}, 32'd1);
    chk("wrap_first_addr",  101, b_addr, 32'hFFFF_FFFC);
    drive(0, 0, 32'h0, 0, 1, 1, 32'h13);
    chk("wrap_second_addr", 102, b_addr, 32'h0000_0000);
    drive(0, 0, 32'h0, 1, 0, 0, 32'h0);
    chk("wrap_head_vld",    103, {31'd0, b_vld}, 32'd1);
    chk("wrap_head_pc",     103, b_pc,   32'hFFFF_FFFC);
    chk("wrap_head_p4",     103, b_p4,   32'h0000_0000);
    chk("wrap_next_req",    103, {31'd0, b_req}, 32'd1);
    chk("wrap_next_addr",   103, b_addr, 32'h0000_0000);

`ifdef IF_PERF_COUNT_EN
    // Memory not ready for 5 cycles, then zero-wait: 7 empty cycles before first instr.
    drive(1, 0, 32'h0, 0, 0, 0, 32'h0);
    drive(1, 0, 32'h0, 0, 0, 0, 32'h0);
    chk("bubbles_reset", 200, a_bubbles, 32'd0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
      chk("bubbles_ramp", 201 + k, a_bubbles, k);
    end
    drive(0, 0, 32'h0, 0, 1, 0, 32'h0);
    drive(0, 0, 32'h0, 0, 1, 1, 32'h13);
    drive(0, 0, 32'h0, 1, 0, 0, 32'h0);
    chk("bubbles_vld",   210, {31'd0, a_vld}, 32'd1);
    chk("bubbles_first", 210, a_bubbles, 32'd7);
    drive(0, 0, 32'h0, 1, 0, 0, 32'h0);
    chk("bubbles_hold",  211, a_bubbles, 32'd7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000; first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port pc_in_data  input  32  redirect target from EX (branch/jump/jalr next PC).
REQ-005 SHALL have port redirect  input  1  take pc_in_data as next fetch PC this cycle.
REQ-006 SHALL have port stall  input  1  downstream (ID) not accepting; head held.
REQ-007 SHALL have port imem_req  output  1  fetch request valid.
REQ-008 SHALL have port imem_addr  output  32  fetch address, word-aligned.
REQ-009 SHALL have port imem_ready  input  1  memory accepts request when imem_req && imem_ready.
REQ-010 SHALL have port imem_rvalid  input  1  response data valid; at least 1 cycle after acceptance.
REQ-011 SHALL have port imem_rdata  input  32  instruction word.
REQ-012 SHALL have port instr  output  32  instruction at buffer head.
REQ-013 SHALL have port instr_valid  output  1  buffer non-empty.
REQ-014 SHALL have port pc_out_data  output  32  PC of head instruction.
REQ-015 SHALL have port plusFour_out_data  output  32  pc_out_data + 4, modulo 2^32.

Function
REQ-016 SHALL hold fetch PC register fpc; imem_addr = {fpc[31:2], 2'b00}.
REQ-017 SHALL implement states FETCH, WAIT, DRAIN; at most one request outstanding.
REQ-018 SHALL assert imem_req only in FETCH with buffer count < 2; on acceptance fpc += 4 (wraps 0xFFFF_FFFC -> 0) and state -> WAIT.
REQ-019 SHALL keep imem_addr stable while imem_req high and not accepted, except on redirect.
REQ-020 SHALL, in WAIT on imem_rvalid, push {fpc_of_request, imem_rdata} into 2-entry FIFO and -> FETCH.
REQ-021 SHALL pop head when instr_valid && !stall; simultaneous push and pop permitted, count unchanged.
REQ-022 SHALL on redirect: flush FIFO (instr_valid 0 next cycle), fpc <= {pc_in_data[31:2], 2'b00}; redirect overrides same-cycle push, pop, and fpc increment.
REQ-023 SHALL go to DRAIN if a request is outstanding after redirect (WAIT without same-cycle rvalid, or FETCH with same-cycle acceptance); else -> FETCH.
REQ-024 SHALL in DRAIN discard response on imem_rvalid and -> FETCH; redirect in DRAIN updates fpc and remains DRAIN.
REQ-025 SHALL ignore imem_rvalid in FETCH.
REQ-026 SHALL give zero-wait latency: acceptance cycle N, rvalid N+1, instr_valid N+2.

Reset
REQ-027 SHALL on rst: fpc = RESET_PC, state FETCH, FIFO empty, instr_valid 0, instr 0, pc_out_data 0, plusFour_out_data 4, imem_req 0 during reset.
REQ-028 SHALL discard any response whose request preceded/overlapped reset: after rst, first rvalid before own acceptance is ignored.
REQ-029 SHALL assert imem_req with imem_addr = RESET_PC in the first cycle after rst deasserts.

Configuration
REQ-030 SHALL, with IF_PERF_COUNT_EN defined, add output fetch_bubbles (32): counts cycles with !instr_valid && !rst, reset to 0, wraps at 2^32.
REQ-031 SHALL, without IF_PERF_COUNT_EN, omit fetch_bubbles and its counter entirely; all other behaviour identical.

Verification
REQ-032 SHALL cover: reset, ready=1, rdata=0x00000013 one cycle later -> addr 0x0,0x4,0x8...; instr_valid cycle 2; pc_out_data 0x0, plusFour_out_data 0x4.
REQ-033 SHALL cover: stall held high, memory zero-wait -> exactly 2 entries buffered (pc 0x0, 0x4), imem_req low until stall drops.
REQ-034 SHALL cover: redirect to 0x0000_0103 while WAIT outstanding -> FIFO flushed, late response discarded, next imem_addr 0x0000_0100, first new instr pc 0x100.
REQ-035 SHALL cover: redirect same cycle as imem_rvalid and pop -> response dropped, count 0, next fetch at target.
REQ-036 SHALL cover: RESET_PC=0xFFFF_FFFC -> second fetch addr 0x0000_0000, plusFour_out_data 0x0 for head at 0xFFFF_FFFC.
REQ-037 SHALL cover (IF_PERF_COUNT_EN): imem_ready low 5 cycles after reset -> fetch_bubbles counts each empty cycle, value 7 at first instr_valid with zero-wait response.
